message_process_cu: RTL and testbench
=====================================

// Module: message_process_cu
// PURPOSE
//  Control unit for message_process_dp. Sequences one 5-bit message transfer: latch, load shift register, enable bit-timing counters, detect end-of-frame (co2).
//  Adds a one-deep pending-request buffer so back-to-back starts are not lost, a watchdog on co2, and an abort path.
//  Sits between the top-level keypad/start logic and the datapath's load_shift_reg/en_cnt/message/co2 pins.
// PARAMETERS
//  MSG_W    5      message width; must match datapath message port
//  TO_W     14     watchdog counter width
//  TIMEOUT  12000  SEND cycles without co2 before the ERR state (> 10 bits x 1024 cycles)
// PORTS
//  clk             in   1      system clock, rising edge
//  reset           in   1      asynchronous, active-low reset
//  start           in   1      request pulse; message_in valid in the same cycle
//  message_in      in   MSG_W  message to send
//  abort           in   1      synchronous abort; highest priority after reset
//  co2             in   1      datapath frame-complete (bit counter terminal carry)
//  load_shift_reg  out  1      to datapath; 1-cycle load strobe
//  en_cnt          out  1      to datapath; bit-timing counter enable
//  message         out  MSG_W  to datapath; held stable from LOAD until the next LOAD
//  busy            out  1      high in every state except IDLE
//  done            out  1      1-cycle pulse when a frame completes
//  err             out  1      high while in the ERR state
//  overflow        out  1      1-cycle pulse when a start is dropped (pending buffer full)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0; message=0; pend_valid=0; watchdog=0.
//  States: IDLE, LOAD, SEND, DONE, ERR. All outputs are registered or a pure decode of state.
//  IDLE:  en_cnt=0. On start=1, capture message_in into msg_reg and go to LOAD next cycle.
//  LOAD:  load_shift_reg=1, en_cnt=0, for exactly one cycle. Clear the watchdog, then go to SEND.
//  SEND:  en_cnt=1; watchdog increments each cycle.
//         co2=1 -> DONE.
//         Otherwise, watchdog==TIMEOUT-1 -> ERR.
//         co2 and timeout in the same cycle: co2 wins.
//  DONE:  done=1, en_cnt=0 for one cycle.
//         pend_valid=1 -> msg_reg<=pend_reg, pend_valid<=0, go to LOAD.
//         Otherwise go to IDLE.
//  ERR:   err=1, en_cnt=0, busy=1. Leaves only on abort (to IDLE). Starts are dropped (overflow pulses). pend_valid is cleared on entry.
//  Latency: start in IDLE at cycle N -> load_shift_reg at N+1 -> en_cnt rises at N+2.
//  Pending buffer: start while state != IDLE/ERR:
//    - pend_valid=0: capture into pend_reg, set pend_valid.
//    - pend_valid=1: drop the request; overflow=1 next cycle.
//    - start in DONE with pend_valid=0 is buffered and served via LOAD after an IDLE cycle.
//  abort=1 in any state: next state IDLE; en_cnt and load_shift_reg drop next cycle; pend_valid=0; done is not pulsed; message holds its last value.
//  Simultaneous abort and start: abort wins and the start is discarded.
//  message output changes only on entry to LOAD, so the datapath never sees a mid-frame change.
//  Watchdog saturates; it never wraps.
// TESTING
//  T1: reset=0 mid-SEND -> all outputs 0 asynchronously; after release, state is IDLE and busy=0.
//  T2: start with message_in=5'b10110 in IDLE -> load_shift_reg one cycle later, message=10110, en_cnt next cycle; co2 after 10240 cycles -> done pulse, busy=0.
//  T3: start A=5'h05, then start B=5'h1A during SEND -> done for A, next cycle LOAD with message=1A, second done; no IDLE gap.
//  T4: three starts during one frame -> 2nd buffered, 3rd raises overflow for 1 cycle; exactly two done pulses.
//  T5: hold co2=0 in SEND -> err=1 at TIMEOUT=12000 cycles, en_cnt=0; abort -> IDLE, err=0.
//  T6: abort and start in the same cycle mid-SEND -> IDLE next cycle, no load, no done, pend_valid=0.

Source files
------------

// File: rtl/message_process_cu.sv
// -----------------------------------------------------------------------------
// message_process_cu
//
// Control unit for message_process_dp. It sequences one MSG_W-bit message
// transfer: latch the message, strobe the datapath shift-register load, enable
// the bit-timing counters, then wait for the datapath's end-of-frame carry (co2).
// A one-deep pending buffer keeps a start that arrives during a frame. A
// watchdog on co2 and a synchronous abort path are also provided.
//
// State table
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for a start, or serving a request left in the buffer
//   LOAD   | one-cycle load strobe to the datapath; watchdog cleared
//   SEND   | bit counters enabled; waiting for co2 or the watchdog
//   DONE   | one-cycle done pulse; chain straight into a buffered request
//   ERR    | co2 never arrived; held until abort
//
// Ports
//   clk             in   1      system clock, rising edge
//   reset           in   1      asynchronous, active-low reset
//   start           in   1      request pulse; message_in valid in the same cycle
//   message_in      in   MSG_W  message to send
//   abort           in   1      synchronous abort, overrides everything but reset
//   co2             in   1      datapath frame-complete carry
//   load_shift_reg  out  1      one-cycle load strobe to the datapath
//   en_cnt          out  1      bit-timing counter enable to the datapath
//   message         out  MSG_W  message to the datapath, changes only entering LOAD
//   busy            out  1      high in every state except IDLE
//   done            out  1      one-cycle pulse when a frame completes
//   err             out  1      high while in ERR
//   overflow        out  1      one-cycle pulse when a start is dropped
// -----------------------------------------------------------------------------
module message_process_cu #(
    parameter int MSG_W   = 5,
    parameter int TO_W    = 14,
    parameter int TIMEOUT = 12000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MSG_W-1:0] message_in,
    input  logic             abort,
    input  logic             co2,
    output logic             load_shift_reg,
    output logic             en_cnt,
    output logic [MSG_W-1:0] message,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             overflow
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] WDOG_MAX  = '1;

    state_t           state, state_nxt;
    logic [MSG_W-1:0] msg_reg, msg_nxt;
    logic [MSG_W-1:0] pend_reg, pend_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic             overflow_nxt;
    logic [TO_W-1:0]  wdog, wdog_nxt;

    // A start seen mid-frame is either kept (buffer empty) or dropped.
    logic             req_capture;
    logic             req_drop;

    assign req_capture = start & ~pend_valid;
    assign req_drop    = start &  pend_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            msg_reg    <= '0;
            pend_reg   <= '0;
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
            wdog       <= '0;
        end else begin
            state      <= state_nxt;
            msg_reg    <= msg_nxt;
            pend_reg   <= pend_nxt;
            pend_valid <= pend_valid_nxt;
            overflow   <= overflow_nxt;
            wdog       <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        msg_nxt        = msg_reg;
        pend_nxt       = pend_reg;
        pend_valid_nxt = pend_valid;
        overflow_nxt   = 1'b0;
        wdog_nxt       = wdog;

        if (abort) begin
            // Any start in the same cycle is discarded silently.
            state_nxt      = S_IDLE;
            pend_valid_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend_valid) begin
                        // Serve the buffered request; a fresh start refills the slot.
                        msg_nxt   = pend_reg;
                        state_nxt = S_LOAD;
                        if (start) begin
                            pend_nxt = message_in;
                        end else begin
                            pend_valid_nxt = 1'b0;
                        end
                    end else if (start) begin
                        msg_nxt   = message_in;
                        state_nxt = S_LOAD;
                    end
                end

                S_LOAD: begin
                    wdog_nxt  = '0;
                    state_nxt = S_SEND;
                    if (req_capture) begin
                        pend_nxt       = message_in;
                        pend_valid_nxt = 1'b1;
                    end
                    overflow_nxt = req_drop;
                end

                S_SEND: begin
                    if (wdog != WDOG_MAX) begin
                        wdog_nxt = wdog + 1'b1;
                    end
                    if (!co2 && (wdog == WDOG_LAST)) begin
                        // The buffer is flushed on the way into ERR, so a start in
                        // this cycle is reported as dropped.
                        state_nxt      = S_ERR;
                        pend_valid_nxt = 1'b0;
                        overflow_nxt   = start;
                    end else begin
                        if (co2) begin
                            state_nxt = S_DONE;
                        end
                        if (req_capture) begin
                            pend_nxt       = message_in;
                            pend_valid_nxt = 1'b1;
                        end
                        overflow_nxt = req_drop;
                    end
                end

                S_DONE: begin
                    if (pend_valid) begin
                        msg_nxt        = pend_reg;
                        pend_valid_nxt = 1'b0;
                        state_nxt      = S_LOAD;
                        overflow_nxt   = start;
                    end else begin
                        // A start here is buffered and picked up from IDLE.
                        state_nxt = S_IDLE;
                        if (start) begin
                            pend_nxt       = message_in;
                            pend_valid_nxt = 1'b1;
                        end
                    end
                end

                S_ERR: begin
                    overflow_nxt = start;
                end

                default: begin
                    state_nxt      = S_IDLE;
                    pend_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign load_shift_reg = (state == S_LOAD);
    assign en_cnt         = (state == S_SEND);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign err            = (state == S_ERR);
    assign message        = msg_reg;

endmodule

// File: tb/tb_message_process_cu.sv
// -----------------------------------------------------------------------------
// tb_message_process_cu
//
// Directed scenarios followed by randomized traffic. Every cycle all outputs
// are compared against a transaction-level reference model: a phase name, the
// message on the datapath, a queue holding at most one waiting request, and a
// count of cycles spent sending.
// -----------------------------------------------------------------------------
module tb_message_process_cu;

    localparam int MSG_W   = 5;
    localparam int TIMEOUT = 12000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [MSG_W-1:0] message_in = '0;
    logic             abort = 1'b0;
    logic             co2 = 1'b0;
    logic             load_shift_reg;
    logic             en_cnt;
    logic [MSG_W-1:0] message;
    logic             busy;
    logic             done;
    logic             err;
    logic             overflow;

    message_process_cu #(
        .MSG_W  (MSG_W),
        .TO_W   (14),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .message_in    (message_in),
        .abort         (abort),
        .co2           (co2),
        .load_shift_reg(load_shift_reg),
        .en_cnt        (en_cnt),
        .message       (message),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    int ovf_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    string            m_ph;
    logic [MSG_W-1:0] m_msg;
    logic [MSG_W-1:0] m_pend[$];
    int               m_send_n;
    logic             m_ov;

    task automatic mdl_reset();
        m_ph     = "idle";
        m_msg    = '0;
        m_pend.delete();
        m_send_n = 0;
        m_ov     = 1'b0;
    endtask

    task automatic mdl_request(input logic s, input logic [MSG_W-1:0] mi);
        if (s) begin
            if (m_pend.size() != 0) m_ov = 1'b1;
            else m_pend.push_back(mi);
        end
    endtask

    task automatic mdl_step(input logic s, input logic [MSG_W-1:0] mi,
                            input logic a, input logic c);
        m_ov = 1'b0;
        if (a) begin
            m_ph = "idle";
            m_pend.delete();
        end else if (m_ph == "idle") begin
            if (m_pend.size() != 0) begin
                m_msg = m_pend.pop_front();
                m_ph  = "load";
                if (s) m_pend.push_back(mi);
            end else if (s) begin
                m_msg = mi;
                m_ph  = "load";
            end
        end else if (m_ph == "load") begin
            mdl_request(s, mi);
            m_send_n = 0;
            m_ph     = "send";
        end else if (m_ph == "send") begin
            m_send_n++;
            if (c) begin
                mdl_request(s, mi);
                m_ph = "done";
            end else if (m_send_n == TIMEOUT) begin
                m_ov = s;
                m_pend.delete();
                m_ph = "err";
            end else begin
                mdl_request(s, mi);
            end
        end else if (m_ph == "done") begin
            if (m_pend.size() != 0) begin
                m_ov  = s;
                m_msg = m_pend.pop_front();
                m_ph  = "load";
            end else begin
                if (s) m_pend.push_back(mi);
                m_ph = "idle";
            end
        end else begin
            m_ov = s;
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_load"},     32'(load_shift_reg), 32'(m_ph == "load"));
        chk({pfx, "_en_cnt"},   32'(en_cnt),         32'(m_ph == "send"));
        chk({pfx, "_busy"},     32'(busy),           32'(m_ph != "idle"));
        chk({pfx, "_done"},     32'(done),           32'(m_ph == "done"));
        chk({pfx, "_err"},      32'(err),            32'(m_ph == "err"));
        chk({pfx, "_overflow"}, 32'(overflow),       32'(m_ov));
        chk({pfx, "_message"},  32'(message),        32'(m_msg));
    endtask

    // Called at a falling edge: drive, clock, advance model, check at next fall.
    task automatic tick(input logic s, input logic [MSG_W-1:0] mi,
                        input logic a, input logic c);
        start      = s;
        message_in = mi;
        abort      = a;
        co2        = c;
        @(posedge clk);
        mdl_step(s, mi, a, c);
        @(negedge clk);
        if (done)     done_seen++;
        if (overflow) ovf_seen++;
        check_all("cyc");
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int d0;
        int o0;
        logic s_r, a_r, c_r;

        mdl_reset();
        repeat (2) @(negedge clk);
        check_all("rst");
        reset = 1'b1;
        idle_ticks(1);

        // T2: single frame, latency and 10240-cycle frame
        tick(1'b1, 5'b10110, 1'b0, 1'b0);
        chk("t2_load_strobe", 32'(load_shift_reg), 32'd1);
        chk("t2_message",     32'(message),        32'h16);
        chk("t2_en_low",      32'(en_cnt),         32'd0);
        idle_ticks(1);
        chk("t2_en_high",     32'(en_cnt),         32'd1);
        idle_ticks(10239);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("t2_done",        32'(done),           32'd1);
        idle_ticks(1);
        chk("t2_idle_busy",   32'(busy),           32'd0);

        // T3: back-to-back frames via the pending buffer, no IDLE gap
        tick(1'b1, 5'h05, 1'b0, 1'b0);
        idle_ticks(3);
        tick(1'b1, 5'h1A, 1'b0, 1'b0);
        idle_ticks(4);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("t3_done_a",      32'(done),           32'd1);
        idle_ticks(1);
        chk("t3_load_b",      32'(load_shift_reg), 32'd1);
        chk("t3_msg_b",       32'(message),        32'h1A);
        idle_ticks(5);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("t3_done_b",      32'(done),           32'd1);
        idle_ticks(2);

        // T4: three starts in one frame -> one buffered, one dropped
        d0 = done_seen;
        o0 = ovf_seen;
        tick(1'b1, 5'h03, 1'b0, 1'b0);
        idle_ticks(2);
        tick(1'b1, 5'h0C, 1'b0, 1'b0);
        tick(1'b1, 5'h11, 1'b0, 1'b0);
        chk("t4_overflow",    32'(overflow),       32'd1);
        idle_ticks(1);
        chk("t4_ovf_pulse",   32'(overflow),       32'd0);
        tick(1'b0, '0, 1'b0, 1'b1);
        idle_ticks(1);
        chk("t4_msg_second",  32'(message),        32'h0C);
        idle_ticks(3);
        tick(1'b0, '0, 1'b0, 1'b1);
        idle_ticks(3);
        chk("t4_done_count",  32'(done_seen - d0), 32'd2);
        chk("t4_ovf_count",   32'(ovf_seen - o0),  32'd1);

        // T5: watchdog expiry after TIMEOUT SEND cycles, then abort
        tick(1'b1, 5'h0F, 1'b0, 1'b0);
        idle_ticks(1);
        idle_ticks(TIMEOUT - 1);
        chk("t5_err_not_yet", 32'(err),            32'd0);
        idle_ticks(1);
        chk("t5_err",         32'(err),            32'd1);
        chk("t5_en_cnt",      32'(en_cnt),         32'd0);
        tick(1'b1, 5'h01, 1'b0, 1'b0);
        chk("t5_err_ovf",     32'(overflow),       32'd1);
        tick(1'b0, '0, 1'b1, 1'b0);
        chk("t5_abort_err",   32'(err),            32'd0);
        chk("t5_abort_busy",  32'(busy),           32'd0);
        idle_ticks(1);

        // T6: abort + start mid-SEND with a request already waiting
        d0 = done_seen;
        tick(1'b1, 5'h07, 1'b0, 1'b0);
        idle_ticks(2);
        tick(1'b1, 5'h19, 1'b0, 1'b0);
        tick(1'b1, 5'h1F, 1'b1, 1'b0);
        chk("t6_busy",        32'(busy),           32'd0);
        chk("t6_msg_hold",    32'(message),        32'h07);
        idle_ticks(3);
        chk("t6_no_load",     32'(load_shift_reg), 32'd0);
        chk("t6_no_done",     32'(done_seen - d0), 32'd0);

        // T1: asynchronous reset in the middle of SEND
        tick(1'b1, 5'h12, 1'b0, 1'b0);
        idle_ticks(3);
        #2;
        reset = 1'b0;
        #1;
        mdl_reset();
        check_all("t1_async");
        @(negedge clk);
        reset = 1'b1;
        check_all("t1_held");
        idle_ticks(1);
        chk("t1_busy",        32'(busy),           32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            s_r = ($urandom_range(0, 3) == 0);
            a_r = ($urandom_range(0, 49) == 0);
            c_r = ($urandom_range(0, 7) == 0);
            tick(s_r, MSG_W'($urandom), a_r, c_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
